cenn_line_sched: RTL
====================

// Module: cenn_line_sched
// PURPOSE
//  Sequencer for the 3-line FIFO buffer that feeds the CeNN 3x3 window. Tracks column/row of the
//  incoming pixel stream, drives the FIFO enable, injects padding lines at frame end, and flags
//  when the three taps (out_1/out_2/out_3) hold a valid window. Also flags which window edges are
//  image borders. Sits between the pixel fixed-point converter and the FIFO + CeNN cell array.
// PARAMETERS
//  LINE_LEN  1024  active pixels per line; must equal the FIFO length
//  FRAME_H   768   active lines per frame (>=2)
// PORTS
//  clk         in   1           system clock
//  rst         in   1           synchronous reset, active-high
//  sof         in   1           start-of-frame pulse, 1 cycle, precedes first pixel
//  pix_valid   in   1           active (non-blanking) pixel present this cycle
//  fifo_en     out  1           drives FIFO enable input (ready_fixed)
//  pad_sel     out  1           1 = FIFO input mux selects boundary constant 15'b000001000000000
//  win_valid   out  1           taps hold a valid window this cycle
//  win_col     out  $clog2(LINE_LEN)  column of the pixel on the taps
//  win_row     out  $clog2(FRAME_H)   row index of center tap (out_2)
//  border      out  4           {top,bottom,left,right} edge of window lies outside image
//  busy        out  1           frame in progress (state != IDLE)
//  frame_done  out  1           1-cycle pulse after last window of frame
//  line_err    out  1           1-cycle pulse on malformed line (LINE_ERR_EN only; else tied 0)
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; in_col=0, in_row=0.
//  - Counters: in_col 0..LINE_LEN-1 increments on each fifo_en cycle, wraps to 0 and increments in_row.
//  - States:
//    IDLE : fifo_en=0. sof -> FILL (in_col=in_row=0). sof in any other state restarts at FILL.
//    FILL : fifo_en=pix_valid. Input row 0. At in_col wrap -> RUN.
//    RUN  : fifo_en=pix_valid. Input rows 1..FRAME_H-1. Wrap on in_row=FRAME_H-1 -> FLUSH.
//    FLUSH: fifo_en=1, pad_sel=1 every cycle, pix_valid ignored, LINE_LEN cycles -> DONE.
//    DONE : 1 cycle, frame_done=1 -> IDLE.
//  - Latency: win_valid/win_col/win_row/border registered, asserted 1 cycle after a fifo_en
//    cycle in RUN or FLUSH (aligned with FIFO output registers). Never in FILL.
//  - win_row = in_row-1 in RUN, FRAME_H-1 in FLUSH; win_col = in_col of the causing fifo_en cycle.
//  - border: top=(win_row==0), bottom=(win_row==FRAME_H-1), left=(win_col==0),
//    right=(win_col==LINE_LEN-1); 0 when win_valid=0.
//  - fifo_en must fall only at line boundaries (FIFO resets addresses when it is low).
//  - pix_valid gap mid-line: counters hold, fifo_en follows pix_valid (no check) unless LINE_ERR_EN.
//  - pix_valid while IDLE/DONE: ignored, fifo_en stays 0.
//  - rst mid-frame: immediate return to IDLE, all outputs 0 next cycle; no frame_done.
// CONFIGURATION
//  LINE_ERR_EN defined: pix_valid low with in_col!=0 in FILL/RUN -> line_err pulse, state->IDLE,
//    fifo_en=0, no frame_done; new sof required. pix_valid high during FLUSH -> line_err pulse,
//    FLUSH continues.
//  LINE_ERR_EN undefined: line_err tied 0; gaps tolerated as above.
// TESTING
//  - rst high 2 cycles mid-RUN -> next cycle all outputs 0, busy=0; later sof restarts at FILL.
//  - LINE_LEN=8, FRAME_H=4, sof + 32 contiguous pixels -> win_valid first 1 cycle after pixel 8,
//    win_row=0 border[3]=1; 32 windows total incl. 8 FLUSH with pad_sel=1; frame_done once.
//  - Same frame, blanking gaps of 5 cycles between lines -> identical window sequence, fifo_en low in gaps.
//  - Check border: (row0,col0)=4'b1010, (row3,col7)=4'b0101, (row1,col3)=4'b0000.
//  - LINE_ERR_EN: drop pix_valid at in_col=3 of row 2 -> line_err 1 cycle, busy=0, no frame_done.
//  - sof asserted during FLUSH -> state FILL, in_row=0, pad_sel=0 next cycle.

Source files
------------

// File: rtl/cenn_line_sched.sv
// Line sequencer for the CeNN 3-line FIFO: tracks column/row of the pixel stream, flushes one
// padding line at frame end and qualifies the 3x3 window taps. Optional feature: `LINE_ERR_EN.
module cenn_line_sched #(
  parameter int LINE_LEN = 1024,
  parameter int FRAME_H  = 768,
  localparam int COL_W = $clog2(LINE_LEN),
  localparam int ROW_W = $clog2(FRAME_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sof,
  input  logic             pix_valid,
  output logic             fifo_en,
  output logic             pad_sel,
  output logic             win_valid,
  output logic [COL_W-1:0] win_col,
  output logic [ROW_W-1:0] win_row,
  output logic [3:0]       border,
  output logic             busy,
  output logic             frame_done,
  output logic             line_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_LEN - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_H - 1);

  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             win_en;
  logic [ROW_W-1:0] win_row_d;
`ifdef LINE_ERR_EN
  logic             err_d;
`endif

  // NOTE: every signal driven here gets a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    fifo_en = 1'b0;
    pad_sel = 1'b0;
`ifdef LINE_ERR_EN
    err_d   = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: ;
      S_FILL, S_RUN: begin
        fifo_en = pix_valid;
`ifdef LINE_ERR_EN
        // A gap inside a line would desynchronise the FIFO taps; abandon the frame.
        if (!pix_valid && col_q != '0) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
          col_d   = '0;
          row_d   = '0;
        end
`endif
        if (pix_valid) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (state_q == S_FILL) begin
              row_d   = ROW_W'(1);
              state_d = S_RUN;
            end else if (row_q == ROW_LAST) begin
              state_d = S_FLUSH;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        fifo_en = 1'b1;
        pad_sel = 1'b1;
`ifdef LINE_ERR_EN
        err_d   = pix_valid;
`endif
        if (col_q == COL_LAST) begin
          col_d   = '0;
          row_d   = '0;
          state_d = S_DONE;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Start-of-frame wins from any state; the FIFO sees enable low for one cycle,
    // which also clears its addresses before the new frame.
    if (sof) begin
      state_d = S_FILL;
      col_d   = '0;
      row_d   = '0;
      fifo_en = 1'b0;
      pad_sel = 1'b0;
`ifdef LINE_ERR_EN
      err_d   = 1'b0;
`endif
    end

    win_en    = fifo_en && (state_q == S_RUN || state_q == S_FLUSH);
    win_row_d = (state_q == S_FLUSH) ? ROW_LAST : row_q - 1'b1;
  end

  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE);

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      win_valid <= 1'b0;
      win_col   <= '0;
      win_row   <= '0;
      border    <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      // Window qualifiers line up with the FIFO output registers, one cycle after enable.
      win_valid <= win_en;
      win_col   <= win_en ? col_q : '0;
      win_row   <= win_en ? win_row_d : '0;
      border    <= win_en ? {win_row_d == '0, win_row_d == ROW_LAST,
                             col_q == '0, col_q == COL_LAST} : 4'b0000;
    end
  end

`ifdef LINE_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) line_err <= 1'b0;
    else     line_err <= err_d;
  end
`else
  assign line_err = 1'b0;
`endif

endmodule
